// File: rtl/micro_sequencer_pkg.sv
// Shared encodings for the microprogrammed control unit sequencer:
// AddrCtl codes, sequencer states and default micro-addresses.
package micro_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_FETCH = 3'd0,
    SEQ_DT1   = 3'd1,
    SEQ_DT2   = 3'd2,
    SEQ_INC   = 3'd3,
    SEQ_WAIT  = 3'd4,
    SEQ_CALL  = 3'd5,
    SEQ_RET   = 3'd6,
    SEQ_HOLD  = 3'd7
  } seq_e;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam int unsigned FETCH_ADDR_DEF = 0;
  localparam int unsigned TRAP_ADDR_DEF  = 31;

endpackage

// File: rtl/micro_sequencer_ret_stack.sv
// Micro-return stack: small LIFO of return addresses.
// Only the pointer is reset; entries keep stale contents.
module micro_ret_stack #(
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH + 1);

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_top;

  assign full  = (r_ptr == PW'(DEPTH));
  assign empty = (r_ptr == '0);
  assign w_top = empty ? '0 : r_ptr - 1'b1;
  assign dout  = r_mem[w_top];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (push && !full) begin
      r_ptr <= r_ptr + 1'b1;
    end else if (pop && !empty) begin
      r_ptr <= r_ptr - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      r_mem[r_ptr] <= din;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address engine of the microprogrammed control unit.
// Holds the micro-PC and chooses its successor from AddrCtl.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int AW         = 5,
  parameter int FETCH_ADDR = FETCH_ADDR_DEF,
  parameter int TRAP_ADDR  = TRAP_ADDR_DEF,
  parameter int RET_DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    addr_ctl,
  input  logic [AW-1:0] u_target,
  input  logic [AW-1:0] dt1_addr,
  input  logic          dt1_valid,
  input  logic [AW-1:0] dt2_addr,
  input  logic          dt2_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] upc,
  output logic          stall,
  output logic          halted,
  output logic          illegal_op,
  output logic          stack_err,
  output logic          wrap_err
);

  localparam logic [AW-1:0] FETCH = AW'(FETCH_ADDR);
  localparam logic [AW-1:0] TRAP  = AW'(TRAP_ADDR);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_upc;
  logic [AW-1:0] w_upc_nxt;
  logic [AW-1:0] w_inc;
  logic          r_illegal;
  logic          r_serr;
  logic          r_werr;
  logic          w_illegal;
  logic          w_serr;
  logic          w_werr;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_ret;
  logic          w_full;
  logic          w_empty;
  seq_e          w_ctl;

  assign w_ctl = seq_e'(addr_ctl);
  assign w_inc = r_upc + 1'b1;

  micro_ret_stack #(
    .AW    (AW),
    .DEPTH (RET_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_inc),
    .dout  (w_ret),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_upc_nxt   = r_upc;
    w_state_nxt = r_state;
    w_illegal   = 1'b0;
    w_serr      = 1'b0;
    w_werr      = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      S_RUN: begin
        unique case (w_ctl)
          SEQ_FETCH: w_upc_nxt = FETCH;
          SEQ_DT1: begin
            w_upc_nxt = dt1_valid ? dt1_addr : TRAP;
            w_illegal = !dt1_valid;
          end
          SEQ_DT2: begin
            w_upc_nxt = dt2_valid ? dt2_addr : TRAP;
            w_illegal = !dt2_valid;
          end
          SEQ_INC: begin
            w_upc_nxt = w_inc;
            w_werr    = (r_upc == '1);
          end
          SEQ_WAIT: begin
            if (mem_ready) w_upc_nxt = w_inc;
            else w_state_nxt = S_WAIT;
          end
          SEQ_CALL: begin
            if (w_full) begin
              w_upc_nxt = TRAP;
              w_serr    = 1'b1;
            end else begin
              w_push    = 1'b1;
              w_upc_nxt = u_target;
            end
          end
          SEQ_RET: begin
            if (w_empty) begin
              w_upc_nxt = TRAP;
              w_serr    = 1'b1;
            end else begin
              w_pop     = 1'b1;
              w_upc_nxt = w_ret;
            end
          end
          SEQ_HOLD: w_state_nxt = S_HALT;
          default: w_upc_nxt = r_upc;
        endcase
      end
      S_WAIT: begin
        if (mem_ready) begin
          w_upc_nxt   = w_inc;
          w_state_nxt = S_RUN;
        end
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_upc     <= FETCH;
      r_illegal <= 1'b0;
      r_serr    <= 1'b0;
      r_werr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_upc     <= w_upc_nxt;
      r_illegal <= w_illegal;
      r_serr    <= w_serr;
      r_werr    <= w_werr;
    end
  end

  assign upc        = r_upc;
  assign stall      = (r_state == S_WAIT);
  assign halted     = (r_state == S_HALT);
  assign illegal_op = r_illegal;
  assign stack_err  = r_serr;
  assign wrap_err   = r_werr;

endmodule
